// File: rtl/voice_allocator_pkg.sv
// MIDI package for voice_allocator: message and voice record types, controller
// numbers, FSM states and a saturating age helper.
package MIDI;

    localparam logic [3:0] MSG_NOTE_OFF         = 4'h8;
    localparam logic [3:0] MSG_NOTE_ON          = 4'h9;
    localparam logic [3:0] MSG_POLY_PRESSURE    = 4'hA;
    localparam logic [3:0] MSG_CONTROL_CHANGE   = 4'hB;
    localparam logic [3:0] MSG_PROGRAM_CHANGE   = 4'hC;
    localparam logic [3:0] MSG_CHANNEL_PRESSURE = 4'hD;
    localparam logic [3:0] MSG_PITCH_BEND       = 4'hE;

    localparam logic [6:0] SUSTAIN_CC       = 7'd64;
    localparam logic [6:0] ALL_NOTES_OFF_CC = 7'd123;

    // Age field is sized for the widest supported AGE_WIDTH (16).
    localparam int AGE_W_MAX = 16;

    typedef struct packed {
        logic [3:0] message_type;
        logic [6:0] data_byte1;
        logic [6:0] data_byte2;
    } message_t;

    typedef struct packed {
        logic                 active;
        logic                 sustained;
        logic [6:0]           note;
        logic [6:0]           velocity;
        logic [AGE_W_MAX-1:0] age;
    } voice_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_APPLY
    } state_t;

    function automatic logic [AGE_W_MAX-1:0] age_sat_inc(
        input logic [AGE_W_MAX-1:0] age,
        input logic [AGE_W_MAX-1:0] age_max
    );
        return (age >= age_max) ? age : age + 1'b1;
    endfunction

endpackage

// File: rtl/voice_allocator_select.sv
// voice_select: combinational priority search for a matching active voice, the
// lowest free voice and the oldest voice (age ties resolve to the lowest index).
module voice_select
    import MIDI::*;
#(
    parameter  int VOICES = 4,
    localparam int IDX_W  = $clog2(VOICES)
) (
    input  logic [VOICES-1:0]                i_active,
    input  logic [VOICES-1:0][6:0]           i_note,
    input  logic [VOICES-1:0][AGE_W_MAX-1:0] i_age,
    input  logic [6:0]                       i_key,
    output logic                             o_match_found,
    output logic [IDX_W-1:0]                 o_match_idx,
    output logic                             o_free_found,
    output logic [IDX_W-1:0]                 o_free_idx,
    output logic [IDX_W-1:0]                 o_oldest_idx
);

    logic [AGE_W_MAX-1:0] w_oldest_age;

    always_comb begin
        o_match_found = 1'b0;
        o_match_idx   = '0;
        o_free_found  = 1'b0;
        o_free_idx    = '0;
        o_oldest_idx  = '0;
        w_oldest_age  = i_age[0];
        // Scanning downward lets the lowest index overwrite any higher hit.
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (i_active[i] && (i_note[i] == i_key)) begin
                o_match_found = 1'b1;
                o_match_idx   = IDX_W'(i);
            end
            if (!i_active[i]) begin
                o_free_found = 1'b1;
                o_free_idx   = IDX_W'(i);
            end
        end
        for (int i = 1; i < VOICES; i++) begin
            if (i_age[i] > w_oldest_age) begin
                w_oldest_age = i_age[i];
                o_oldest_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic MIDI voice allocator: IDLE -> LOOKUP -> APPLY per message.
// Define VOICE_STEAL_EN to steal the oldest voice instead of dropping a NOTE_ON.
module voice_allocator
    import MIDI::*;
#(
    parameter int VOICES    = 4,
    parameter int AGE_WIDTH = 8
) (
    input  logic                   clock_50_000_000,
    input  logic                   reset_l,
    input  message_t               message,
    input  logic                   message_ready,
    output logic                   busy,
    output logic [VOICES-1:0]      voice_active,
    output logic [VOICES-1:0][6:0] voice_note,
    output logic [VOICES-1:0][6:0] voice_velocity,
    output logic [VOICES-1:0]      voice_trigger,
    output logic [VOICES-1:0]      voice_release,
    output logic                   overflow
);

    localparam int IDX_W = $clog2(VOICES);
    localparam logic [AGE_W_MAX-1:0] AGE_MAX = AGE_W_MAX'((1 << AGE_WIDTH) - 1);

    state_t                           r_state, w_state_nxt;
    message_t                         r_msg;
    voice_t                           r_voices     [VOICES];
    voice_t                           w_voices_nxt [VOICES];
    logic                             r_sustain, w_sustain_nxt;
    logic [VOICES-1:0]                r_trigger, w_trigger;
    logic [VOICES-1:0]                r_release, w_release;
    logic                             r_overflow, w_overflow;
    logic                             r_match_found, r_free_found;
    logic [IDX_W-1:0]                 r_match_idx, r_free_idx, r_oldest_idx;
    logic                             w_match_found, w_free_found;
    logic [IDX_W-1:0]                 w_match_idx, w_free_idx, w_oldest_idx;
    logic [VOICES-1:0]                w_active;
    logic [VOICES-1:0][6:0]           w_note;
    logic [VOICES-1:0][AGE_W_MAX-1:0] w_age;
    logic                             w_note_on, w_note_off, w_cc, w_assign;
    logic [IDX_W-1:0]                 w_tgt;

    always_ff @(posedge clock_50_000_000) begin
        if (!reset_l) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            S_IDLE:   if (message_ready) w_state_nxt = S_LOOKUP;
            S_LOOKUP: begin
                busy        = 1'b1;
                w_state_nxt = S_APPLY;
            end
            S_APPLY:  begin
                busy        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_50_000_000) begin
        if (!reset_l)                              r_msg <= '0;
        else if (r_state == S_IDLE && message_ready) r_msg <= message;
    end

    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            w_active[i] = r_voices[i].active;
            w_note[i]   = r_voices[i].note;
            w_age[i]    = r_voices[i].age;
        end
    end

    voice_select #(.VOICES(VOICES)) u_select (
        .i_active      (w_active),
        .i_note        (w_note),
        .i_age         (w_age),
        .i_key         (r_msg.data_byte1),
        .o_match_found (w_match_found),
        .o_match_idx   (w_match_idx),
        .o_free_found  (w_free_found),
        .o_free_idx    (w_free_idx),
        .o_oldest_idx  (w_oldest_idx)
    );

    // LOOKUP: freeze the search results for the APPLY cycle.
    always_ff @(posedge clock_50_000_000) begin
        if (!reset_l) begin
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_oldest_idx  <= '0;
        end else if (r_state == S_LOOKUP) begin
            r_match_found <= w_match_found;
            r_match_idx   <= w_match_idx;
            r_free_found  <= w_free_found;
            r_free_idx    <= w_free_idx;
            r_oldest_idx  <= w_oldest_idx;
        end
    end

    // A NOTE_ON with velocity 0 is the running-status form of NOTE_OFF.
    assign w_note_on  = (r_msg.message_type == MSG_NOTE_ON) && (r_msg.data_byte2 != 7'd0);
    assign w_note_off = (r_msg.message_type == MSG_NOTE_OFF) ||
                        ((r_msg.message_type == MSG_NOTE_ON) && (r_msg.data_byte2 == 7'd0));
    assign w_cc       = (r_msg.message_type == MSG_CONTROL_CHANGE);

    // APPLY: next voice state and the one-cycle pulses.
    always_comb begin
        w_voices_nxt  = r_voices;
        w_trigger     = '0;
        w_release     = '0;
        w_overflow    = 1'b0;
        w_sustain_nxt = r_sustain;
        w_assign      = 1'b0;
        w_tgt         = '0;
        if (r_state == S_APPLY) begin
            if (w_note_on) begin
                if (r_match_found) begin
                    w_assign = 1'b1;
                    w_tgt    = r_match_idx;
                end else if (r_free_found) begin
                    w_assign = 1'b1;
                    w_tgt    = r_free_idx;
                end else begin
`ifdef VOICE_STEAL_EN
                    w_assign                = 1'b1;
                    w_tgt                   = r_oldest_idx;
                    w_release[r_oldest_idx] = 1'b1;
`else
                    w_overflow = 1'b1;
`endif
                end
            end
            if (w_note_off) begin
                for (int i = 0; i < VOICES; i++) begin
                    if (r_voices[i].active && r_voices[i].note == r_msg.data_byte1) begin
                        if (r_sustain) begin
                            w_voices_nxt[i].sustained = 1'b1;
                        end else begin
                            w_voices_nxt[i].active = 1'b0;
                            w_release[i]           = 1'b1;
                        end
                    end
                end
            end
            if (w_cc && r_msg.data_byte1 == SUSTAIN_CC) begin
                if (r_msg.data_byte2 >= 7'd64) begin
                    w_sustain_nxt = 1'b1;
                end else begin
                    w_sustain_nxt = 1'b0;
                    for (int i = 0; i < VOICES; i++) begin
                        if (r_voices[i].sustained) begin
                            w_voices_nxt[i].active    = 1'b0;
                            w_voices_nxt[i].sustained = 1'b0;
                            w_release[i]              = 1'b1;
                        end
                    end
                end
            end
            if (w_cc && r_msg.data_byte1 == ALL_NOTES_OFF_CC) begin
                w_sustain_nxt = 1'b0;
                for (int i = 0; i < VOICES; i++) begin
                    if (r_voices[i].active) w_release[i] = 1'b1;
                    w_voices_nxt[i].active    = 1'b0;
                    w_voices_nxt[i].sustained = 1'b0;
                end
            end
            if (w_assign) begin
                for (int i = 0; i < VOICES; i++) begin
                    if (IDX_W'(i) == w_tgt) begin
                        w_voices_nxt[i].active    = 1'b1;
                        w_voices_nxt[i].sustained = 1'b0;
                        w_voices_nxt[i].note      = r_msg.data_byte1;
                        w_voices_nxt[i].velocity  = r_msg.data_byte2;
                        w_voices_nxt[i].age       = '0;
                        w_trigger[i]              = 1'b1;
                    end else if (r_voices[i].active) begin
                        w_voices_nxt[i].age = age_sat_inc(r_voices[i].age, AGE_MAX);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_50_000_000) begin
        if (!reset_l) begin
            for (int i = 0; i < VOICES; i++) r_voices[i] <= '0;
            r_sustain  <= 1'b0;
            r_trigger  <= '0;
            r_release  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_voices   <= w_voices_nxt;
            r_sustain  <= w_sustain_nxt;
            r_trigger  <= w_trigger;
            r_release  <= w_release;
            r_overflow <= w_overflow;
        end
    end

    always_comb begin
        for (int i = 0; i < VOICES; i++) begin
            voice_active[i]   = r_voices[i].active;
            voice_note[i]     = r_voices[i].note;
            voice_velocity[i] = r_voices[i].velocity;
        end
    end

    assign voice_trigger = r_trigger;
    assign voice_release = r_release;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed table-driven bench for voice_allocator (VOICES=4), plus hand-written
// sequences for retrigger, sustain, busy strobes, reset in APPLY and all-notes-off.
module tb_voice_allocator;
    import MIDI::*;

    logic                clk = 1'b0;
    logic                reset_l;
    message_t            message;
    logic                message_ready;
    logic                busy;
    logic [3:0]          voice_active, voice_trigger, voice_release;
    logic [3:0][6:0]     voice_note, voice_velocity;
    logic                overflow;

    int n_checks = 0;
    int n_pass   = 0;

    voice_allocator #(.VOICES(4), .AGE_WIDTH(8)) dut (
        .clock_50_000_000 (clk),
        .reset_l          (reset_l),
        .message          (message),
        .message_ready    (message_ready),
        .busy             (busy),
        .voice_active     (voice_active),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity),
        .voice_trigger    (voice_trigger),
        .voice_release    (voice_release),
        .overflow         (overflow)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [3:0]      mtype;
        logic [6:0]      b1;
        logic [6:0]      b2;
        logic [3:0]      act;
        logic [3:0][6:0] note;
        logic [3:0][6:0] vel;
        logic [3:0]      trig;
        logic [3:0]      rel;
        logic            ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic do_reset();
        reset_l       = 1'b0;
        message_ready = 1'b0;
        message       = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_l = 1'b1;
    endtask

    // Strobe one message; returns #1 after the edge where the result lands.
    task automatic send(input logic [3:0] t, input logic [6:0] a, input logic [6:0] b);
        message.message_type = t;
        message.data_byte1   = a;
        message.data_byte2   = b;
        message_ready        = 1'b1;
        @(posedge clk); #1;
        message_ready = 1'b0;
        check("busy_lookup", busy, 1);
        @(posedge clk); #1;
        check("busy_apply", busy, 1);
        check("no_early_trigger", voice_trigger, 0);
        @(posedge clk); #1;
        check("busy_done", busy, 0);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] act, input logic [27:0] note,
                              input logic [27:0] vel, input logic [3:0] trig,
                              input logic [3:0] rel, input logic ovf);
        check({tag, "_active"},   voice_active,   act);
        check({tag, "_note"},     voice_note,     note);
        check({tag, "_velocity"}, voice_velocity, vel);
        check({tag, "_trigger"},  voice_trigger,  trig);
        check({tag, "_release"},  voice_release,  rel);
        check({tag, "_overflow"}, overflow,       ovf);
    endtask

    logic [3:0][6:0] n_full, v_full, n4, v4;
    logic [3:0]      t4, r4;
    logic            o4;

    initial begin
        n_full = {7'd65, 7'd64, 7'd62, 7'd60};
        v_full = {7'd70, 7'd80, 7'd90, 7'd100};
`ifdef VOICE_STEAL_EN
        n4 = {7'd65, 7'd64, 7'd62, 7'd67};
        v4 = {7'd70, 7'd80, 7'd90, 7'd60};
        t4 = 4'b0001; r4 = 4'b0001; o4 = 1'b0;
`else
        n4 = n_full;
        v4 = v_full;
        t4 = 4'b0000; r4 = 4'b0000; o4 = 1'b1;
`endif
        vecs[0] = '{MSG_NOTE_ON, 7'd60, 7'd100, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd60},
                    {7'd0, 7'd0, 7'd0, 7'd100}, 4'b0001, 4'b0000, 1'b0};
        vecs[1] = '{MSG_NOTE_ON, 7'd62, 7'd90, 4'b0011, {7'd0, 7'd0, 7'd62, 7'd60},
                    {7'd0, 7'd0, 7'd90, 7'd100}, 4'b0010, 4'b0000, 1'b0};
        vecs[2] = '{MSG_NOTE_ON, 7'd64, 7'd80, 4'b0111, {7'd0, 7'd64, 7'd62, 7'd60},
                    {7'd0, 7'd80, 7'd90, 7'd100}, 4'b0100, 4'b0000, 1'b0};
        vecs[3] = '{MSG_NOTE_ON, 7'd65, 7'd70, 4'b1111, n_full, v_full, 4'b1000, 4'b0000, 1'b0};
        vecs[4] = '{MSG_NOTE_ON, 7'd67, 7'd60, 4'b1111, n4, v4, t4, r4, o4};
        vecs[5] = '{MSG_NOTE_OFF, 7'd62, 7'd0, 4'b1101, n4, v4, 4'b0000, 4'b0010, 1'b0};
        vecs[6] = '{MSG_PROGRAM_CHANGE, 7'd5, 7'd0, 4'b1101, n4, v4, 4'b0000, 4'b0000, 1'b0};
        vecs[7] = '{MSG_CONTROL_CHANGE, 7'd7, 7'd100, 4'b1101, n4, v4, 4'b0000, 4'b0000, 1'b0};
        vecs[8] = '{MSG_CONTROL_CHANGE, ALL_NOTES_OFF_CC, 7'd0, 4'b0000, n4, v4,
                    4'b0000, 4'b1101, 1'b0};

        do_reset();
        check("reset_busy", busy, 0);
        expect_out("reset", 4'b0000, '0, '0, 4'b0000, 4'b0000, 1'b0);

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].mtype, vecs[i].b1, vecs[i].b2);
            expect_out($sformatf("vec%0d", i), vecs[i].act, vecs[i].note, vecs[i].vel,
                       vecs[i].trig, vecs[i].rel, vecs[i].ovf);
        end

        // Retrigger of an already-sounding note.
        do_reset();
        send(MSG_NOTE_ON, 7'd60, 7'd100);
        send(MSG_NOTE_ON, 7'd62, 7'd90);
        send(MSG_NOTE_ON, 7'd60, 7'd40);
        expect_out("retrig", 4'b0011, {7'd0, 7'd0, 7'd62, 7'd60}, {7'd0, 7'd0, 7'd90, 7'd40},
                   4'b0001, 4'b0000, 1'b0);
        check("retrig_age0", dut.r_voices[0].age, 0);
        check("retrig_age1", dut.r_voices[1].age, 1);

        // Sustain pedal holds a released note until the pedal lifts.
        send(MSG_CONTROL_CHANGE, SUSTAIN_CC, 7'd127);
        check("sus_on", dut.r_sustain, 1);
        send(MSG_NOTE_OFF, 7'd60, 7'd0);
        check("sus_hold_active", voice_active, 4'b0011);
        check("sus_hold_release", voice_release, 4'b0000);
        check("sus_flag_set", dut.r_voices[0].sustained, 1);
        send(MSG_CONTROL_CHANGE, SUSTAIN_CC, 7'd0);
        expect_out("sus_off", 4'b0010, {7'd0, 7'd0, 7'd62, 7'd60}, {7'd0, 7'd0, 7'd90, 7'd40},
                   4'b0000, 4'b0001, 1'b0);
        check("sus_flag_clr", dut.r_voices[0].sustained, 0);
        check("sus_off_flag", dut.r_sustain, 0);

        // A strobe during LOOKUP must be ignored.
        message = '{MSG_NOTE_ON, 7'd70, 7'd50};
        message_ready = 1'b1;
        @(posedge clk); #1;
        message = '{MSG_NOTE_ON, 7'd71, 7'd55};
        @(posedge clk); #1;
        message_ready = 1'b0;
        @(posedge clk); #1;
        expect_out("busy_ign", 4'b0011, {7'd0, 7'd0, 7'd62, 7'd70}, {7'd0, 7'd0, 7'd90, 7'd50},
                   4'b0001, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("busy_ign_quiet%0d", i), {busy, voice_trigger}, 5'b0);
        end
        check("busy_ign_active", voice_active, 4'b0011);

        // Reset asserted while the message is in APPLY.
        message = '{MSG_NOTE_ON, 7'd72, 7'd60};
        message_ready = 1'b1;
        @(posedge clk); #1;
        message_ready = 1'b0;
        @(posedge clk); #1;
        reset_l = 1'b0;
        @(posedge clk); #1;
        check("rst_apply_busy", busy, 0);
        expect_out("rst_apply", 4'b0000, '0, '0, 4'b0000, 4'b0000, 1'b0);
        reset_l = 1'b1;
        @(posedge clk); #1;
        check("rst_apply_after", {busy, voice_trigger, voice_release, overflow}, 10'b0);

        // All-notes-off clears sustain and every voice.
        send(MSG_NOTE_ON, 7'd60, 7'd100);
        send(MSG_NOTE_ON, 7'd62, 7'd90);
        send(MSG_NOTE_ON, 7'd64, 7'd80);
        send(MSG_CONTROL_CHANGE, SUSTAIN_CC, 7'd100);
        send(MSG_CONTROL_CHANGE, ALL_NOTES_OFF_CC, 7'd0);
        expect_out("cc123", 4'b0000, {7'd0, 7'd64, 7'd62, 7'd60}, {7'd0, 7'd80, 7'd90, 7'd100},
                   4'b0000, 4'b0111, 1'b0);
        check("cc123_sustain", dut.r_sustain, 0);
        @(posedge clk); #1;
        check("cc123_pulse_end", voice_release, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
